// File: rtl/temp_monitor_multi.sv
// Multi-channel temperature supervisor: registered hottest-channel reduction,
// debounced latched alarm with operator acknowledge, and hysteretic fan control.
module temp_monitor_multi #(
  parameter int unsigned W         = 5,
  parameter int unsigned N         = 4,
  parameter int unsigned T_FAN_ON  = 20,
  parameter int unsigned T_FAN_OFF = 18,
  parameter int unsigned T_ALARM   = 28,
  parameter int unsigned DEBOUNCE  = 3
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 en_m1,
  input  logic [N*W-1:0]                       temperatura,
  input  logic                                 lect,
  output logic                                 est_ventilador,
  output logic                                 est_alarma,
  output logic [1:0]                           estados,
  output logic [W-1:0]                         max_temp,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] max_chan,
  output logic [N-1:0]                         alarm_chan
);

  localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DCW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DCW-1:0] DMAX = DCW'(DEBOUNCE - 1);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_NORMAL = 2'b01;
  localparam logic [1:0] S_FAN    = 2'b10;
  localparam logic [1:0] S_ALARM  = 2'b11;

  if (!((T_FAN_OFF <= T_FAN_ON) && (T_FAN_ON < T_ALARM))) begin : g_bad_thresholds
    $error("temp_monitor_multi: thresholds must satisfy T_FAN_OFF <= T_FAN_ON < T_ALARM");
  end
  if (N < 1) begin : g_bad_n
    $error("temp_monitor_multi: N must be at least 1");
  end
  if (DEBOUNCE < 1) begin : g_bad_debounce
    $error("temp_monitor_multi: DEBOUNCE must be at least 1");
  end

  logic [W-1:0]   max_temp_q, max_temp_d;
  logic [CW-1:0]  max_chan_q, max_chan_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic [1:0]     state_q, state_d;
  logic           fan_q, alarm_q;
  logic [N-1:0]   alarm_chan_q, alarm_chan_d;
  logic [N-1:0]   chan_hot;
  logic           over_alarm, hot, leave_alarm;

  // Unsigned max reduction; strict '>' keeps the lowest index on ties.
  always_comb begin
    max_temp_d = temperatura[W-1:0];
    max_chan_d = '0;
    chan_hot   = '0;
    for (int i = 0; i < int'(N); i++) begin
      chan_hot[i] = (32'(temperatura[i*W +: W]) >= T_ALARM);
      if (temperatura[i*W +: W] > max_temp_d) begin
        max_temp_d = temperatura[i*W +: W];
        max_chan_d = CW'(i);
      end
    end
  end

  assign over_alarm = (32'(max_temp_q) >= T_ALARM);
  assign hot        = en_m1 && over_alarm && (dcnt_q == DMAX);

  always_comb begin
    dcnt_d = '0;
    if (en_m1 && over_alarm) begin
      dcnt_d = (dcnt_q == DMAX) ? dcnt_q : dcnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q != S_ALARM) && hot) begin
      state_d = S_ALARM;
    end else begin
      case (state_q)
        S_ALARM: begin
          if (lect && !over_alarm) begin
            state_d = (32'(max_temp_q) >= T_FAN_OFF) ? S_FAN : S_NORMAL;
          end
        end
        S_IDLE: begin
          if (en_m1) state_d = S_NORMAL;
        end
        S_NORMAL: begin
          if (!en_m1)                             state_d = S_IDLE;
          else if (32'(max_temp_q) >= T_FAN_ON)   state_d = S_FAN;
        end
        S_FAN: begin
          if (!en_m1)                             state_d = S_IDLE;
          else if (32'(max_temp_q) < T_FAN_OFF)   state_d = S_NORMAL;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The acknowledge wipes the mask, but a channel still over threshold on that edge re-arms it.
  assign leave_alarm = (state_q == S_ALARM) && (state_d != S_ALARM);

  always_comb begin
    alarm_chan_d = leave_alarm ? '0 : alarm_chan_q;
    if (en_m1) alarm_chan_d = alarm_chan_d | chan_hot;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      max_temp_q   <= '0;
      max_chan_q   <= '0;
      dcnt_q       <= '0;
      state_q      <= S_IDLE;
      fan_q        <= 1'b0;
      alarm_q      <= 1'b0;
      alarm_chan_q <= '0;
    end else begin
      if (en_m1) begin
        max_temp_q <= max_temp_d;
        max_chan_q <= max_chan_d;
      end
      dcnt_q       <= dcnt_d;
      state_q      <= state_d;
      fan_q        <= (state_d == S_FAN) || (state_d == S_ALARM);
      alarm_q      <= (state_d == S_ALARM);
      alarm_chan_q <= alarm_chan_d;
    end
  end

  assign est_ventilador = fan_q;
  assign est_alarma     = alarm_q;
  assign estados        = state_q;
  assign max_temp       = max_temp_q;
  assign max_chan       = max_chan_q;
  assign alarm_chan     = alarm_chan_q;

endmodule

// File: tb/tb_temp_monitor_multi.sv
// Bench for temp_monitor_multi: directed scenarios followed by randomized traffic,
// all checked against a behavioural model of the supervisor rules.
module tb_temp_monitor_multi;

  localparam int W     = 5;
  localparam int N     = 4;
  localparam int T_ON  = 20;
  localparam int T_OFF = 18;
  localparam int T_AL  = 28;
  localparam int DEB   = 3;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           en_m1;
  logic [N*W-1:0] temperatura;
  logic           lect;
  logic           est_ventilador;
  logic           est_alarma;
  logic [1:0]     estados;
  logic [W-1:0]   max_temp;
  logic [1:0]     max_chan;
  logic [N-1:0]   alarm_chan;

  always #5 clock = ~clock;

  temp_monitor_multi #(
    .W(W), .N(N), .T_FAN_ON(T_ON), .T_FAN_OFF(T_OFF), .T_ALARM(T_AL), .DEBOUNCE(DEB)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .en_m1          (en_m1),
    .temperatura    (temperatura),
    .lect           (lect),
    .est_ventilador (est_ventilador),
    .est_alarma     (est_alarma),
    .estados        (estados),
    .max_temp       (max_temp),
    .max_chan       (max_chan),
    .alarm_chan     (alarm_chan)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: state as 0..3 (IDLE, NORMAL, FAN, ALARM).
  int           m_max, m_chan, m_run, m_state;
  logic [N-1:0] m_achan;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_max   = 0;
    m_chan  = 0;
    m_run   = 0;
    m_state = 0;
    m_achan = '0;
  endtask

  // Applies the supervisor rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    int v[N];
    int nmax, nchan, nxt;
    bit qual, hot, leave;
    for (int i = 0; i < N; i++) v[i] = int'(temperatura[i*W +: W]);
    qual  = en_m1 && (m_max >= T_AL);
    m_run = qual ? m_run + 1 : 0;
    hot   = qual && (m_run >= DEB);
    nxt   = m_state;
    if (m_state != 3 && hot) nxt = 3;
    else if (m_state == 3) begin
      if (lect && m_max < T_AL) nxt = (m_max >= T_OFF) ? 2 : 1;
    end
    else if (!en_m1) nxt = 0;
    else if (m_state == 0) nxt = 1;
    else if (m_state == 1 && m_max >= T_ON) nxt = 2;
    else if (m_state == 2 && m_max < T_OFF) nxt = 1;
    leave = (m_state == 3) && (nxt != 3);
    if (leave) m_achan = '0;
    if (en_m1) begin
      for (int i = 0; i < N; i++) if (v[i] >= T_AL) m_achan[i] = 1'b1;
      nmax = v[0];
      nchan = 0;
      for (int i = 1; i < N; i++) begin
        if (v[i] > nmax) begin
          nmax = v[i];
          nchan = i;
        end
      end
      m_max  = nmax;
      m_chan = nchan;
    end
    m_state = nxt;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, "_estados"}, 32'(estados), 32'(m_state));
    chk({ctx, "_fan"},     32'(est_ventilador), 32'(m_state >= 2));
    chk({ctx, "_alarm"},   32'(est_alarma), 32'(m_state == 3));
    chk({ctx, "_max"},     32'(max_temp), 32'(m_max));
    chk({ctx, "_chan"},    32'(max_chan), 32'(m_chan));
    chk({ctx, "_achan"},   32'(alarm_chan), 32'(m_achan));
  endtask

  task automatic step(input string ctx);
    model_edge();
    @(posedge clock);
    #1;
    check_all(ctx);
  endtask

  task automatic set_all(input int a, input int b, input int c, input int d);
    temperatura = {5'(d), 5'(c), 5'(b), 5'(a)};
  endtask

  task automatic check_zero(input string ctx);
    chk({ctx, "_estados0"}, 32'(estados), 32'd0);
    chk({ctx, "_fan0"},     32'(est_ventilador), 32'd0);
    chk({ctx, "_alarm0"},   32'(est_alarma), 32'd0);
    chk({ctx, "_max0"},     32'(max_temp), 32'd0);
    chk({ctx, "_chan0"},    32'(max_chan), 32'd0);
    chk({ctx, "_achan0"},   32'(alarm_chan), 32'd0);
  endtask

  initial begin
    int ramp[5];
    int hold;
    ramp = '{10, 20, 25, 19, 17};
    en_m1 = 1'b0;
    lect  = 1'b0;
    temperatura = '0;
    model_reset();
    #1 reset = 1'b0;
    #1 check_zero("reset");
    #10 reset = 1'b1;

    // Enable with every channel at 10.
    en_m1 = 1'b1;
    set_all(10, 10, 10, 10);
    step("enable");
    chk("en_estados", 32'(estados), 32'd1);
    chk("en_max", 32'(max_temp), 32'd10);
    chk("en_fan", 32'(est_ventilador), 32'd0);
    chk("en_alarm", 32'(est_alarma), 32'd0);

    // Channel 2 ramp with fan hysteresis.
    for (int r = 0; r < 5; r++) begin
      set_all(5, 5, ramp[r], 5);
      for (int k = 0; k < 4; k++) begin
        step("ramp");
        chk("ramp_chan", 32'(max_chan), 32'd2);
        if (r == 1 && k == 0) chk("ramp_fan_wait", 32'(est_ventilador), 32'd0);
        if (r == 1 && k == 1) chk("ramp_fan_on", 32'(est_ventilador), 32'd1);
        if (r == 3 && k == 3) chk("ramp_fan_hyst", 32'(est_ventilador), 32'd1);
        if (r == 4 && k == 0) chk("ramp_fan_lag", 32'(est_ventilador), 32'd1);
        if (r == 4 && k == 1) chk("ramp_fan_off", 32'(est_ventilador), 32'd0);
      end
    end

    // Short excursion to 28 must not raise the alarm.
    set_all(5, 28, 5, 5);
    step("short28");
    step("short28");
    set_all(5, 25, 5, 5);
    for (int k = 0; k < 4; k++) begin
      step("after28");
      chk("short_no_alarm", 32'(est_alarma), 32'd0);
    end

    // Sustained 30 on channel 1: alarm exactly DEBOUNCE+1 edges later.
    set_all(5, 30, 5, 5);
    for (int k = 1; k <= 4; k++) begin
      step("hot30");
      if (k < 4) chk("hot_pre_alarm", 32'(est_alarma), 32'd0);
    end
    chk("hot_alarm", 32'(est_alarma), 32'd1);
    chk("hot_estados", 32'(estados), 32'd3);
    chk("hot_achan", 32'(alarm_chan), 32'b0010);
    set_all(5, 25, 5, 5);
    for (int k = 0; k < 3; k++) begin
      step("latch25");
      chk("latch_cool", 32'(est_alarma), 32'd1);
    end
    en_m1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step("latch_dis");
      chk("latch_dis_state", 32'(estados), 32'd3);
    end

    // Acknowledge at 25 returns to FAN.
    lect = 1'b1;
    step("ack25");
    chk("ack25_state", 32'(estados), 32'd2);
    chk("ack25_fan", 32'(est_ventilador), 32'd1);
    chk("ack25_achan", 32'(alarm_chan), 32'd0);
    lect  = 1'b0;
    en_m1 = 1'b1;

    // Re-enter the alarm, then acknowledge at 12 to reach NORMAL.
    set_all(5, 30, 5, 5);
    for (int k = 0; k < 4; k++) step("rehot");
    chk("rehot_alarm", 32'(est_alarma), 32'd1);
    set_all(5, 12, 5, 5);
    step("cool12");
    chk("cool12_hold", 32'(estados), 32'd3);
    lect = 1'b1;
    step("ack12");
    chk("ack12_state", 32'(estados), 32'd1);
    chk("ack12_achan", 32'(alarm_chan), 32'd0);
    lect = 1'b0;

    // Tie between channels 0 and 3.
    set_all(22, 5, 5, 22);
    step("tie");
    chk("tie_chan", 32'(max_chan), 32'd0);
    chk("tie_max", 32'(max_temp), 32'd22);

    // Asynchronous reset while alarmed.
    set_all(5, 30, 5, 5);
    for (int k = 0; k < 4; k++) step("prerst");
    chk("prerst_alarm", 32'(est_alarma), 32'd1);
    #2 reset = 1'b0;
    #1 check_zero("arst");
    model_reset();
    #2 reset = 1'b1;

    // Randomized traffic with held values, occasional acknowledge and resets.
    for (int n = 0; n < 600; n++) begin
      en_m1 = ($urandom_range(0, 9) != 0);
      lect  = ($urandom_range(0, 4) == 0);
      set_all($urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31));
      hold = $urandom_range(1, 4);
      for (int k = 0; k < hold; k++) step("rand");
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        check_all("rand_arst");
        #1 reset = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
